row_result_accumulator: RTL

ROW_RESULT_ACCUMULATOR -- requirements
Module: row_result_accumulator

---
 rtl/row_result_if.sv | 28 ++
 rtl/row_result_accumulator.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/row_result_if.sv
// Streaming handshake bundle between the PE row, the row result
// accumulator and the next-layer slide buffer.
interface row_result_if;
    logic [7:0] in_data;
    logic       in_val;
    logic       in_ready;
    logic [6:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output in_data,
        output in_val,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_val,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/row_result_accumulator.sv
// Row result accumulator: sums cfg_tiles signed partial sums plus a bias.
// Each finished group is shifted, passed through ReLU and clamped to 7 bits.
// The result is queued in a 4-entry FIFO for the next layer.
module row_result_accumulator (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [3:0]  cfg_tiles,
    input  logic [7:0]  cfg_bias,
    input  logic [2:0]  cfg_shift,
    row_result_if.slave bus,
    output logic        ovf,
    output logic        busy
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_POST = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;

    logic [3:0]         tiles_r;
    logic [7:0]         bias_r;
    logic [2:0]         shift_r;

    logic signed [12:0] acc_r;
    logic [3:0]         cnt_r;
    logic               ovf_r;

    logic [6:0]         mem_r [0:3];
    logic [1:0]         wr_ptr_r;
    logic [1:0]         rd_ptr_r;
    logic [2:0]         fifo_cnt_r;

    logic               pending_s;
    logic [3:0]         occupancy_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               drop_s;
    logic               first_s;
    logic               last_s;
    logic               push_s;
    logic               pop_s;
    logic [6:0]         post_s;

    // Arithmetic shift, then ReLU, then clamp into the unsigned 7-bit range.
    function automatic logic [6:0] post_process(input logic signed [12:0] acc,
                                                input logic [2:0] shamt);
        logic signed [12:0] y;
        y = acc >>> shamt;
        if (y < 13'sd0) begin
            return 7'd0;
        end else if (y > 13'sd127) begin
            return 7'd127;
        end else begin
            return y[6:0];
        end
    endfunction

    // Handshake qualifiers; a pending POST result reserves its FIFO slot up front.
    always_comb begin
        pending_s   = (state_r == ST_POST);
        occupancy_s = {1'b0, fifo_cnt_r} + {3'b000, pending_s};
        in_ready_s  = (occupancy_s < 4'd4);
        accept_s    = bus.in_val & in_ready_s & ~clr;
        drop_s      = bus.in_val & ~in_ready_s & ~clr;
        first_s     = (cnt_r == 4'd0);
        last_s      = (cnt_r == (tiles_r - 4'd1));
        push_s      = pending_s & ~clr;
        pop_s       = (fifo_cnt_r != 3'd0) & bus.out_ready & ~clr;
        post_s      = post_process(acc_r, shift_r);
    end

    // Next-state logic; a beat taken in POST immediately opens the next group.
    always_comb begin
        state_s = state_r;
        if (clr) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_POST: begin
                    if (accept_s) begin
                        state_s = last_s ? ST_POST : ST_ACC;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ACC: begin
                    if (accept_s && last_s) begin
                        state_s = ST_POST;
                    end else begin
                        state_s = ST_ACC;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Config latch, accumulator, tile counter and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tiles_r <= 4'd1;
            bias_r  <= 8'd0;
            shift_r <= 3'd0;
            acc_r   <= 13'sd0;
            cnt_r   <= 4'd0;
            ovf_r   <= 1'b0;
        end else if (clr) begin
            tiles_r <= (cfg_tiles == 4'd0) ? 4'd1 : cfg_tiles;
            bias_r  <= cfg_bias;
            shift_r <= cfg_shift;
            acc_r   <= 13'sd0;
            cnt_r   <= 4'd0;
            ovf_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                if (first_s) begin
                    acc_r <= {{5{bias_r[7]}}, bias_r} + {{5{bus.in_data[7]}}, bus.in_data};
                end else begin
                    acc_r <= acc_r + {{5{bus.in_data[7]}}, bus.in_data};
                end
                cnt_r <= last_s ? 4'd0 : (cnt_r + 4'd1);
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Result FIFO: written in POST, popped by the consumer, emptied by clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mem_r[i] <= 7'd0;
            end
            wr_ptr_r   <= 2'd0;
            rd_ptr_r   <= 2'd0;
            fifo_cnt_r <= 3'd0;
        end else if (clr) begin
            wr_ptr_r   <= 2'd0;
            rd_ptr_r   <= 2'd0;
            fifo_cnt_r <= 3'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= post_s;
                wr_ptr_r        <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 3'd1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 3'd1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (fifo_cnt_r != 3'd0);
    assign bus.out_data  = mem_r[rd_ptr_r];
    assign ovf           = ovf_r;
    assign busy          = (cnt_r != 4'd0);
endmodule
